// File: rtl/fabric_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fabric_cfg_pkg
// Shared definitions for the configuration-fabric column logic.
//   - fsm_state_t     : frame strobe sequencer states (IDLE/SETUP/STROBE/HOLD)
//   - COL_BROADCAST   : all-ones column address, addresses every column at once
//   - PHASE_CNT_W     : width of the shared SETUP/STROBE phase counter
//   - PHASE_CNT_MAX   : largest phase length the counter can time
//   - clamp_phase()   : folds a phase-length parameter into 1..PHASE_CNT_MAX
// -----------------------------------------------------------------------------
package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } fsm_state_t;

    // Wide all-ones; users slice it down to their column address width.
    localparam logic [31:0] COL_BROADCAST = 32'hFFFF_FFFF;

    localparam int PHASE_CNT_W   = 4;
    localparam int PHASE_CNT_MAX = (1 << PHASE_CNT_W) - 1;

    // A phase of length 0 would never reach the terminal count of 1, and a
    // length beyond the counter range would wrap, so both are folded back
    // into the legal range rather than silently hanging the sequencer.
    function automatic logic [PHASE_CNT_W-1:0] clamp_phase(input int cycles);
        logic [PHASE_CNT_W-1:0] v;
        if (cycles < 1) begin
            v = PHASE_CNT_W'(1);
        end else if (cycles > PHASE_CNT_MAX) begin
            v = PHASE_CNT_W'(PHASE_CNT_MAX);
        end else begin
            v = PHASE_CNT_W'(cycles);
        end
        return v;
    endfunction

endpackage

// File: rtl/frame_strobe_timer.sv
// -----------------------------------------------------------------------------
// frame_strobe_timer
// Loadable down-counter timing the SETUP and STROBE phases of the frame
// strobe sequencer. The phase ends on the cycle the counter reads 1, so a
// load value of N keeps the phase active for exactly N cycles.
// Ports:
//   CLK          in   1       configuration clock
//   resetn       in   1       asynchronous active-low reset
//   i_load       in   1       load i_load_val on the next edge (wins over i_dec)
//   i_load_val   in   W       phase length in cycles
//   i_dec        in   1       count down by one (holds at zero)
//   o_terminal   out  1       counter reads 1: last cycle of the current phase
// -----------------------------------------------------------------------------
module frame_strobe_timer
    import fabric_cfg_pkg::*;
#(
    parameter int W = PHASE_CNT_W
) (
    input  logic         CLK,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_terminal
);

    logic [W-1:0] r_count;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_terminal = (r_count == W'(1));

endmodule

// File: rtl/frame_strobe_gen.sv
// -----------------------------------------------------------------------------
// frame_strobe_gen
// Per-column configuration frame strobe generator. Accepts a (column, frame)
// write request from the configuration controller and, when the column
// matches, produces a single registered one-hot pulse on FrameStrobe,
// framed by a FrameData setup phase before and a one-cycle hold after.
//
// Sequence after a request handshake at the end of cycle 0 (S=SetupCycles,
// W=StrobeCycles):
//   cycles 1..S          SETUP   FrameStrobe = 0
//   cycles S+1..S+W      STROBE  FrameStrobe = 1 << frame
//   cycle  S+W+1         HOLD    FrameStrobe = 0, done_o = 1
//   cycle  S+W+2         IDLE    req_ready_o = 1
//
// Optional build macro:
//   FRAME_STROBE_COUNT_EN  strobe_count_o counts completed strobe phases
//                          (saturating 16-bit); otherwise tied to zero.
//
// Ports:
//   CLK             in   1                 configuration clock
//   resetn          in   1                 asynchronous active-low reset
//   req_valid_i     in   1                 write request valid
//   req_ready_o     out  1                 request can be accepted (IDLE only)
//   col_sel_i       in   ColSelectWidth    target column (all-ones = broadcast)
//   frame_sel_i     in   FrameSelectWidth  target frame index
//   FrameStrobe     out  MaxFramesPerCol   registered one-hot strobe bus
//   busy_o          out  1                 sequence in progress
//   done_o          out  1                 pulse: strobe sequence completed
//   err_o           out  1                 pulse: out-of-range frame for this column
//   strobe_count_o  out  16                completed strobe phases
// -----------------------------------------------------------------------------
module frame_strobe_gen
    import fabric_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameSelectWidth = 5,
    parameter int ColSelectWidth   = 5,
    parameter int ColIndex         = 0,
    parameter int SetupCycles      = 1,
    parameter int StrobeCycles     = 2
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [ColSelectWidth-1:0]   col_sel_i,
    input  logic [FrameSelectWidth-1:0] frame_sel_i,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [15:0]                 strobe_count_o
);

    localparam logic [ColSelectWidth-1:0] COL_ADDR  = ColSelectWidth'(ColIndex);
    localparam logic [ColSelectWidth-1:0] COL_BCAST = COL_BROADCAST[ColSelectWidth-1:0];
    // One extra bit so MaxFramesPerCol itself is representable in the compare.
    localparam logic [FrameSelectWidth:0] FRAME_LIMIT = (FrameSelectWidth + 1)'(MaxFramesPerCol);
    localparam logic [PHASE_CNT_W-1:0]    SETUP_LOAD  = clamp_phase(SetupCycles);
    localparam logic [PHASE_CNT_W-1:0]    STROBE_LOAD = clamp_phase(StrobeCycles);

    fsm_state_t                   r_state;
    logic [FrameSelectWidth-1:0]  r_frame_q;
    logic [MaxFramesPerCol-1:0]   r_frame_strobe;
    logic                         r_ready;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_err;

    logic                         w_accept;
    logic                         w_col_match;
    logic                         w_frame_ok;
    logic                         w_start;
    logic                         w_terminal;
    logic                         w_setup_done;
    logic                         w_strobe_done;
    logic                         w_timer_load;
    logic [PHASE_CNT_W-1:0]       w_timer_load_val;
    logic                         w_timer_dec;
    logic [MaxFramesPerCol-1:0]   w_onehot;

    // ---------------------------------------------------------------------
    // Request decode. Ready is only high in IDLE, so an accept always
    // happens from IDLE and inputs are naturally ignored while busy.
    // ---------------------------------------------------------------------
    assign w_accept    = req_valid_i && r_ready;
    assign w_col_match = (col_sel_i == COL_ADDR) || (col_sel_i == COL_BCAST);
    assign w_frame_ok  = ({1'b0, frame_sel_i} < FRAME_LIMIT);
    assign w_start     = w_accept && w_col_match && w_frame_ok;

    // ---------------------------------------------------------------------
    // Shared phase timer: loaded with the SETUP length on accept and with
    // the STROBE length on the last SETUP cycle.
    // ---------------------------------------------------------------------
    assign w_setup_done     = (r_state == ST_SETUP)  && w_terminal;
    assign w_strobe_done    = (r_state == ST_STROBE) && w_terminal;
    assign w_timer_load     = w_start || w_setup_done;
    assign w_timer_load_val = w_start ? SETUP_LOAD : STROBE_LOAD;
    assign w_timer_dec      = (r_state == ST_SETUP) || (r_state == ST_STROBE);

    frame_strobe_timer #(
        .W          (PHASE_CNT_W)
    ) u_timer (
        .CLK        (CLK),
        .resetn     (resetn),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_load_val),
        .i_dec      (w_timer_dec),
        .o_terminal (w_terminal)
    );

    // ---------------------------------------------------------------------
    // Frame index to one-hot. Only indices below MaxFramesPerCol can be
    // latched, so exactly one bit is set whenever the strobe is loaded.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_onehot
            assign w_onehot[gi] = (r_frame_q == FrameSelectWidth'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Sequencer. All outputs are registered here so the strobe bus leaving
    // the column foot is glitch-free; the async reset drops it immediately.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_frame_q      <= '0;
            r_frame_strobe <= '0;
            r_ready        <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_col_match) begin
                        if (w_frame_ok) begin
                            r_frame_q <= frame_sel_i;
                            r_state   <= ST_SETUP;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_terminal) begin
                        r_state        <= ST_STROBE;
                        r_frame_strobe <= w_onehot;
                    end
                end
                ST_STROBE: begin
                    if (w_terminal) begin
                        r_state        <= ST_HOLD;
                        r_frame_strobe <= '0;
                        r_done         <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_frame_strobe <= '0;
                    r_ready        <= 1'b1;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign FrameStrobe = r_frame_strobe;
    assign req_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;

    // ---------------------------------------------------------------------
    // Optional strobe counter: one count per STROBE -> HOLD transition.
    // ---------------------------------------------------------------------
`ifdef FRAME_STROBE_COUNT_EN
    logic [15:0] r_strobe_count;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_strobe_count <= 16'h0;
        end else if (w_strobe_done && (r_strobe_count != 16'hFFFF)) begin
            r_strobe_count <= r_strobe_count + 16'd1;
        end
    end

    assign strobe_count_o = r_strobe_count;
`else
    assign strobe_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_frame_strobe_gen.sv
// -----------------------------------------------------------------------------
// tb_frame_strobe_gen
// Self-checking bench for frame_strobe_gen: directed table of cycle vectors,
// hand-written reset / back-to-back sequences and randomized traffic, all
// checked against a timeline model (cycles elapsed since the last accept).
// -----------------------------------------------------------------------------
module tb_frame_strobe_gen;

    localparam int MAXF   = 20;
    localparam int FSW    = 5;
    localparam int CSW    = 5;
    localparam int COLIDX = 0;
    localparam int S      = 1;
    localparam int W      = 2;
    localparam int PERIOD = S + W + 2;
`ifdef FRAME_STROBE_COUNT_EN
    localparam int EXP_B2B_COUNT = 10;
    localparam bit COUNT_EN      = 1'b1;
`else
    localparam int EXP_B2B_COUNT = 0;
    localparam bit COUNT_EN      = 1'b0;
`endif

    logic            CLK;
    logic            resetn;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [CSW-1:0]  col_sel_i;
    logic [FSW-1:0]  frame_sel_i;
    logic [MAXF-1:0] FrameStrobe;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic [15:0]     strobe_count_o;

    frame_strobe_gen #(
        .MaxFramesPerCol  (MAXF),
        .FrameSelectWidth (FSW),
        .ColSelectWidth   (CSW),
        .ColIndex         (COLIDX),
        .SetupCycles      (S),
        .StrobeCycles     (W)
    ) dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .col_sel_i      (col_sel_i),
        .frame_sel_i    (frame_sel_i),
        .FrameStrobe    (FrameStrobe),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .strobe_count_o (strobe_count_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Timeline model: m_phase = cycles since the accepting edge (0 = idle).
    int m_phase = 0;
    int m_fq    = 0;
    bit m_err   = 1'b0;
    int m_count = 0;
    int dut_accepts = 0;

    typedef struct packed {
        logic            v;
        logic [CSW-1:0]  col;
        logic [FSW-1:0]  frm;
        logic [MAXF-1:0] e_strobe;
        logic            e_done;
        logic            e_err;
        logic            e_ready;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_err   = 1'b0;
        m_count = 0;
    endtask

    task automatic model_edge(input logic v, input int c, input int f);
        m_err = 1'b0;
        if (m_phase == 0) begin
            if (v && (c == COLIDX || c == (1 << CSW) - 1)) begin
                if (f < MAXF) begin
                    m_phase = 1;
                    m_fq    = f;
                    $display("accept: col=%0d frame=%0d", c, f);
                end else begin
                    m_err = 1'b1;
                    $display("reject: col=%0d frame=%0d out of range", c, f);
                end
            end
        end else begin
            m_phase++;
            if (m_phase == S + W + 1 && COUNT_EN && m_count < 65535) m_count++;
            if (m_phase == S + W + 2) m_phase = 0;
        end
    endtask

    task automatic check_model();
        logic [31:0] exp_strobe;
        exp_strobe = (m_phase >= S + 1 && m_phase <= S + W) ? (32'd1 << m_fq) : 32'd0;
        chk("strobe", 32'(FrameStrobe), exp_strobe);
        chk("ready",  32'(req_ready_o), 32'(m_phase == 0));
        chk("busy",   32'(busy_o),      32'(m_phase != 0));
        chk("done",   32'(done_o),      32'(m_phase == S + W + 1));
        chk("err",    32'(err_o),       32'(m_err));
        chk("count",  32'(strobe_count_o), 32'(m_count));
    endtask

    // Called at a falling edge: drive, clock, then check at the next falling edge.
    task automatic cycle(input logic v, input logic [CSW-1:0] c, input logic [FSW-1:0] f);
        req_valid_i = v;
        col_sel_i   = c;
        frame_sel_i = f;
        if (v && req_ready_o) dut_accepts++;
        @(posedge CLK);
        model_edge(v, int'(c), int'(f));
        @(negedge CLK);
        check_model();
    endtask

    initial begin
        logic [CSW-1:0] rc;
        logic [FSW-1:0] rf;
        logic           rv;

        resetn      = 1'b0;
        req_valid_i = 1'b0;
        col_sel_i   = '0;
        frame_sel_i = '0;
        model_reset();

        // Test 1: column match, frame 3
        vq.push_back('{1'b1, 5'd0,  5'd3,  20'h00000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 5'd0,  5'd0,  20'h00008, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 5'd0,  5'd0,  20'h00008, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 5'd0,  5'd0,  20'h00000, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 5'd0,  5'd0,  20'h00000, 1'b0, 1'b0, 1'b1});
        // Test 2: other column is ignored
        vq.push_back('{1'b1, 5'd1,  5'd3,  20'h00000, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b0, 5'd1,  5'd3,  20'h00000, 1'b0, 1'b0, 1'b1});
        // Test 3: broadcast, top frame; a request while busy is ignored
        vq.push_back('{1'b1, 5'd31, 5'd19, 20'h00000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 5'd0,  5'd5,  20'h80000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 5'd0,  5'd0,  20'h80000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 5'd0,  5'd0,  20'h00000, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 5'd0,  5'd0,  20'h00000, 1'b0, 1'b0, 1'b1});
        // Test 4: out-of-range frame, then first illegal index 20
        vq.push_back('{1'b1, 5'd0,  5'd25, 20'h00000, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b0, 5'd0,  5'd0,  20'h00000, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b1, 5'd31, 5'd20, 20'h00000, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b0, 5'd0,  5'd0,  20'h00000, 1'b0, 1'b0, 1'b1});

        repeat (2) @(negedge CLK);
        chk("rst_strobe", 32'(FrameStrobe), 32'd0);
        chk("rst_ready",  32'(req_ready_o), 32'd1);
        chk("rst_busy",   32'(busy_o),      32'd0);
        chk("rst_done",   32'(done_o),      32'd0);
        chk("rst_err",    32'(err_o),       32'd0);
        chk("rst_count",  32'(strobe_count_o), 32'd0);
        resetn = 1'b1;
        @(negedge CLK);

        // Directed table
        for (int i = 0; i < vq.size(); i++) begin
            cycle(vq[i].v, vq[i].col, vq[i].frm);
            $display("vec %0d: v=%0b col=%0d frame=%0d -> strobe=0x%0h done=%0b err=%0b ready=%0b",
                     i, vq[i].v, vq[i].col, vq[i].frm, FrameStrobe, done_o, err_o, req_ready_o);
            chk($sformatf("vec%0d_strobe", i), 32'(FrameStrobe), 32'(vq[i].e_strobe));
            chk($sformatf("vec%0d_done", i),   32'(done_o),      32'(vq[i].e_done));
            chk($sformatf("vec%0d_err", i),    32'(err_o),       32'(vq[i].e_err));
            chk($sformatf("vec%0d_ready", i),  32'(req_ready_o), 32'(vq[i].e_ready));
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rv = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       rc = CSW'(COLIDX);
                1:       rc = '1;
                2:       rc = CSW'(COLIDX + 1);
                default: rc = CSW'($urandom_range(0, 31));
            endcase
            rf = ($urandom_range(0, 3) == 0) ? FSW'($urandom_range(20, 31))
                                              : FSW'($urandom_range(0, 19));
            cycle(rv, rc, rf);
        end
        for (int i = 0; i < PERIOD; i++) cycle(1'b0, '0, '0);

        // Test 5: reset during STROBE
        cycle(1'b1, CSW'(COLIDX), 5'd7);
        cycle(1'b0, '0, '0);
        chk("pre_rst_strobe", 32'(FrameStrobe), 32'h80);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_strobe", 32'(FrameStrobe), 32'd0);
        chk("rst_mid_ready",  32'(req_ready_o), 32'd1);
        chk("rst_mid_busy",   32'(busy_o),      32'd0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        for (int i = 0; i < PERIOD; i++) cycle(1'b0, '0, '0);

        // Test 6: 10 back-to-back requests with valid held high
        dut_accepts = 0;
        for (int i = 0; i < 10 * PERIOD; i++) cycle(1'b1, CSW'(COLIDX), FSW'($urandom_range(0, 19)));
        for (int i = 0; i < PERIOD + 1; i++) cycle(1'b0, '0, '0);
        chk("b2b_accepts", 32'(dut_accepts), 32'd10);
        chk("b2b_count",   32'(strobe_count_o), 32'(EXP_B2B_COUNT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
